// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions.
// State codes, frame width and default bit period.
package uart_rx_pkg;

  localparam int UART_BITS        = 8;
  localparam int DEF_BAUD_DIVIDER = 104;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser with falling-edge detect.
// Flops preset high so an idle-high pin never fakes an edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic s1;
  logic s2;
  logic d3;

  // Resynchronise the pin and keep one delayed copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      d3 <= 1'b1;
    end else begin
      s1 <= din;
      s2 <= s1;
      d3 <= s2;
    end
  end

  assign dout = s2;
  assign fall = d3 & ~s2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first.
// Samples each bit centre; flags bad stop bits on FE.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD_DIVIDER = DEF_BAUD_DIVIDER
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Rx,
  output logic [UART_BITS-1:0] O_DATA,
  output logic                 NrD,
  output logic                 RiP,
  output logic                 FE
);

  localparam int HALF_DIV = BAUD_DIVIDER / 2;
  localparam int CW       = $clog2(BAUD_DIVIDER);

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIVIDER - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(UART_BITS - 1);

  logic                 rx_s;
  logic                 fall;
  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic [UART_BITS-1:0] shift;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (Rx),
    .dout (rx_s),
    .fall (fall)
  );

  // Frame FSM: start check, data shift, stop check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      O_DATA  <= '0;
      NrD     <= 1'b0;
      FE      <= 1'b0;
    end else begin
      NrD <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (fall) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt == BAUD_LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[UART_BITS-1:1]};
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == BIT_LAST) state <= RX_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == BAUD_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_s) begin
              O_DATA <= shift;
              NrD    <= 1'b1;
              FE     <= 1'b0;
            end else begin
              FE <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= RX_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign RiP = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx with a 16-cycle bit period.
// Serial model drives frames; scoreboard checks bytes.
module tb_uart_rx;

  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Rx  = 1'b1;
  logic [7:0] O_DATA;
  logic       NrD;
  logic       RiP;
  logic       FE;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic rip_seen = 1'b0;

  uart_rx #(.BAUD_DIVIDER(BD)) dut (
    .clk    (clk),
    .rst    (rst),
    .Rx     (Rx),
    .O_DATA (O_DATA),
    .NrD    (NrD),
    .RiP    (RiP),
    .FE     (FE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    Rx = b;
    repeat (BD) @(negedge clk);
  endtask

  // Start bit, first nbits data bits, then stop if all 8 sent.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (nbits == 8) send_bit(stop);
  endtask

  task automatic idle(input int n);
    Rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare every NrD pulse against the scoreboard.
  always @(negedge clk) begin
    if (RiP) rip_seen = 1'b1;
    if (rst && NrD) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_nrd got %02h want none", O_DATA);
      end else begin
        automatic logic [7:0] e = sb.pop_front();
        chk("rx_byte", 32'(O_DATA), 32'(e));
        chk("fe_on_good", 32'(FE), 32'd0);
      end
    end
  end

  initial begin
    // 1. reset
    repeat (5) @(negedge clk);
    chk("rst_data", 32'(O_DATA), 32'h00);
    chk("rst_nrd", 32'(NrD), 32'd0);
    chk("rst_rip", 32'(RiP), 32'd0);
    chk("rst_fe", 32'(FE), 32'd0);
    rst = 1'b1;
    idle(5);
    chk("rip_after_rst", 32'(RiP), 32'd0);

    // 2. single byte
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 8);
    chk("rip_end_a5", 32'(RiP), 32'd0);
    chk("fe_a5", 32'(FE), 32'd0);
    idle(BD);

    // 3. back-to-back
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    send_frame(8'h00, 1'b1, 8);
    send_frame(8'hFF, 1'b1, 8);
    idle(BD);
    chk("b2b_data", 32'(O_DATA), 32'hFF);
    chk("b2b_fe", 32'(FE), 32'd0);

    // 4. glitch shorter than half a bit
    rip_seen = 1'b0;
    Rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(2 * BD);
    chk("glitch_rip_seen", 32'(rip_seen), 32'd1);
    chk("glitch_rip_low", 32'(RiP), 32'd0);
    chk("glitch_data", 32'(O_DATA), 32'hFF);

    // 5. framing error then recovery
    send_frame(8'h3C, 1'b0, 8);
    idle(2 * BD);
    chk("fe_set", 32'(FE), 32'd1);
    chk("fe_data_kept", 32'(O_DATA), 32'hFF);
    sb.push_back(8'h55);
    send_frame(8'h55, 1'b1, 8);
    idle(BD);
    chk("fe_cleared", 32'(FE), 32'd0);
    chk("data_55", 32'(O_DATA), 32'h55);

    // 6. reset in the middle of a frame
    send_frame(8'h81, 1'b1, 4);
    rst = 1'b0;
    #1;
    chk("mid_rst_data", 32'(O_DATA), 32'h00);
    chk("mid_rst_nrd", 32'(NrD), 32'd0);
    chk("mid_rst_rip", 32'(RiP), 32'd0);
    chk("mid_rst_fe", 32'(FE), 32'd0);
    idle(4);
    rst = 1'b1;
    idle(BD);
    sb.push_back(8'h81);
    send_frame(8'h81, 1'b1, 8);
    idle(2 * BD);
    chk("final_data", 32'(O_DATA), 32'h81);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
